// File: rtl/blackjack_hand_scorer_pkg.sv
// rtl/blackjack_hand_scorer_pkg.sv - shared encodings and limits for the blackjack hand scorer
package blackjack_hand_scorer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEAL   = 3'd1,
    ST_PLAYER = 3'd2,
    ST_DEALER = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  localparam int WIN_PLAYER = 0;
  localparam int WIN_DEALER = 1;
  localparam int WIN_PUSH   = 2;
  localparam int WIN_PBUST  = 3;
  localparam int WIN_DBUST  = 4;

  localparam int MAX_CARD   = 10;
  localparam int BJ_LIMIT   = 21;
  localparam int DEAL_CARDS = 4;

  function automatic logic card_ok(input logic [4:0] v);
    return (v >= 5'd1) && (v <= 5'(MAX_CARD));
  endfunction

endpackage

// File: rtl/blackjack_hand_accum.sv
// rtl/blackjack_hand_accum.sv - one hand: raw card sum plus ace flag, ace-adjusted score
module blackjack_hand_accum
  import blackjack_hand_scorer_pkg::*;
#(
  parameter int HAND_W   = 5,
  parameter bit ACE_HIGH = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              add,
  input  logic [4:0]        value,
  output logic [HAND_W-1:0] score
);

  logic [HAND_W-1:0] raw_q, raw_d;
  logic              ace_q, ace_d;
  logic [HAND_W:0]   soft_w;

  always_comb begin
    raw_d = raw_q;
    ace_d = ace_q;
    if (clear) begin
      raw_d = '0;
      ace_d = 1'b0;
    end else if (add) begin
      raw_d = raw_q + HAND_W'(value);
      ace_d = ace_q | (value == 5'd1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      raw_q <= '0;
      ace_q <= 1'b0;
    end else begin
      raw_q <= raw_d;
      ace_q <= ace_d;
    end
  end

  // One bit wider so a large raw sum cannot wrap into a "soft" score.
  assign soft_w = {1'b0, raw_q} + (HAND_W+1)'(10);
  assign score  = (ACE_HIGH && ace_q && (soft_w <= (HAND_W+1)'(BJ_LIMIT)))
                  ? soft_w[HAND_W-1:0] : raw_q;

endmodule

// File: rtl/blackjack_hand_scorer.sv
// rtl/blackjack_hand_scorer.sv - deal/hit/stand/dealer-draw flow with card req/valid handshake
module blackjack_hand_scorer
  import blackjack_hand_scorer_pkg::*;
#(
  parameter int DEALER_STAND = 17,
  parameter bit ACE_HIGH     = 1'b1,
  parameter int HAND_W       = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              new_game,
  input  logic              hit,
  input  logic              stand,
  output logic              card_req,
  input  logic              card_valid,
  input  logic [4:0]        card_value,
  output logic [HAND_W-1:0] phand,
  output logic [HAND_W-1:0] dhand,
  output logic [4:0]        winner,
  output logic              busy
);

  state_e      state_q, state_d;
  logic        ng_prev_q, hit_prev_q, stand_prev_q;
  logic        ng_pulse, hit_pulse, stand_pulse;
  logic        busy_q, busy_d;
  logic        req_q, req_d;
  logic        tgt_dealer_q, tgt_dealer_d;
  logic [2:0]  deal_cnt_q, deal_cnt_d;
  logic [4:0]  winner_q, winner_d;
  logic [4:0]  result_flags;
  logic        issue, issue_dealer, accept, p_add, d_add;

  assign ng_pulse    = new_game & ~ng_prev_q;
  assign hit_pulse   = hit & ~hit_prev_q;
  assign stand_pulse = stand & ~stand_prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ng_prev_q    <= 1'b0;
      hit_prev_q   <= 1'b0;
      stand_prev_q <= 1'b0;
      busy_q       <= 1'b0;
      req_q        <= 1'b0;
      tgt_dealer_q <= 1'b0;
      deal_cnt_q   <= '0;
      winner_q     <= '0;
    end else begin
      state_q      <= state_d;
      ng_prev_q    <= new_game;
      hit_prev_q   <= hit;
      stand_prev_q <= stand;
      busy_q       <= busy_d;
      req_q        <= req_d;
      tgt_dealer_q <= tgt_dealer_d;
      deal_cnt_q   <= deal_cnt_d;
      winner_q     <= winner_d;
    end
  end

  // Decisions are taken only with no request outstanding, so scores are settled.
  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    issue_dealer = 1'b0;
    if (ng_pulse) begin
      state_d = ST_DEAL;
    end else if (!busy_q) begin
      case (state_q)
        ST_DEAL: begin
          if (deal_cnt_q == 3'(DEAL_CARDS)) begin
            state_d = (phand == HAND_W'(BJ_LIMIT)) ? ST_DEALER : ST_PLAYER;
          end else begin
            issue        = 1'b1;
            issue_dealer = deal_cnt_q[0];
          end
        end
        ST_PLAYER: begin
          if (phand > HAND_W'(BJ_LIMIT))       state_d = ST_RESULT;
          else if (phand == HAND_W'(BJ_LIMIT)) state_d = ST_DEALER;
          else if (stand_pulse)                state_d = ST_DEALER;
          else if (hit_pulse)                  issue   = 1'b1;
        end
        ST_DEALER: begin
          if (dhand < HAND_W'(DEALER_STAND)) begin
            issue        = 1'b1;
            issue_dealer = 1'b1;
          end else begin
            state_d = ST_RESULT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    result_flags = '0;
    if (phand > HAND_W'(BJ_LIMIT)) begin
      result_flags[WIN_PBUST]  = 1'b1;
      result_flags[WIN_DEALER] = 1'b1;
    end else if (dhand > HAND_W'(BJ_LIMIT)) begin
      result_flags[WIN_DBUST]  = 1'b1;
      result_flags[WIN_PLAYER] = 1'b1;
    end else if (phand > dhand) begin
      result_flags[WIN_PLAYER] = 1'b1;
    end else if (dhand > phand) begin
      result_flags[WIN_DEALER] = 1'b1;
    end else begin
      result_flags[WIN_PUSH] = 1'b1;
    end
  end

  // The request cycle itself never accepts, enforcing at least one cycle of latency.
  always_comb begin
    accept       = busy_q & ~req_q & card_valid & card_ok(card_value) & ~ng_pulse;
    p_add        = accept & ~tgt_dealer_q;
    d_add        = accept & tgt_dealer_q;
    req_d        = issue;
    busy_d       = busy_q;
    tgt_dealer_d = tgt_dealer_q;
    deal_cnt_d   = deal_cnt_q;
    winner_d     = winner_q;
    if (ng_pulse) begin
      busy_d     = 1'b0;
      deal_cnt_d = '0;
      winner_d   = '0;
    end else begin
      if (issue) begin
        busy_d       = 1'b1;
        tgt_dealer_d = issue_dealer;
      end else if (accept) begin
        busy_d = 1'b0;
        if (state_q == ST_DEAL) deal_cnt_d = deal_cnt_q + 3'd1;
      end
      if (state_d == ST_RESULT && state_q != ST_RESULT) winner_d = result_flags;
    end
  end

  blackjack_hand_accum #(.HAND_W(HAND_W), .ACE_HIGH(ACE_HIGH)) u_player (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (ng_pulse),
    .add     (p_add),
    .value   (card_value),
    .score   (phand)
  );

  blackjack_hand_accum #(.HAND_W(HAND_W), .ACE_HIGH(ACE_HIGH)) u_dealer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (ng_pulse),
    .add     (d_add),
    .value   (card_value),
    .score   (dhand)
  );

  assign card_req = req_q;
  assign busy     = busy_q;
  assign winner   = winner_q;

endmodule

// File: tb/tb_blackjack_hand_scorer.sv
// tb/tb_blackjack_hand_scorer.sv - directed table and sequence checks for blackjack_hand_scorer
module tb_blackjack_hand_scorer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       new_game = 1'b0;
  logic       hit = 1'b0;
  logic       stand = 1'b0;
  logic       card_req;
  logic       card_valid = 1'b0;
  logic [4:0] card_value = 5'd0;
  logic [4:0] phand, dhand, winner;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int req_cnt = 0;
  int base;

  always #5 clock = ~clock;

  always @(posedge clock) if (card_req) req_cnt <= req_cnt + 1;

  blackjack_hand_scorer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .new_game   (new_game),
    .hit        (hit),
    .stand      (stand),
    .card_req   (card_req),
    .card_valid (card_valid),
    .card_value (card_value),
    .phand      (phand),
    .dhand      (dhand),
    .winner     (winner),
    .busy       (busy)
  );

  typedef struct packed {
    logic [4:0] c0, c1, c2, c3;
    logic       act;
    logic [4:0] e0, e1;
    logic [1:0] n;
    logic [4:0] p, d, w;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  task automatic wait_busy();
    int i;
    i = 0;
    while (!busy && i < 100) begin
      tick();
      i++;
    end
  endtask

  task automatic serve(input logic [4:0] v, input int lat);
    wait_busy();
    chk("serve_busy", int'(busy), 1);
    repeat (lat) tick();
    card_valid = 1'b1;
    card_value = v;
    tick();
    card_valid = 1'b0;
    card_value = 5'd0;
  endtask

  task automatic wait_winner();
    int i;
    i = 0;
    while (winner == 5'd0 && i < 200) begin
      tick();
      i++;
    end
  endtask

  initial begin
    // cards c0..c3, act (1=hit), extras, n extras, exp phand, dhand, winner
    vecs[0] = '{5'd10, 5'd9, 5'd7, 5'd8, 1'b0, 5'd0, 5'd0, 2'd0, 5'd17, 5'd17, 5'b00100};
    vecs[1] = '{5'd1, 5'd5, 5'd10, 5'd6, 1'b1, 5'd4, 5'd5, 2'd2, 5'd21, 5'd20, 5'b00001};
    vecs[2] = '{5'd10, 5'd10, 5'd6, 5'd7, 1'b1, 5'd9, 5'd0, 2'd1, 5'd25, 5'd17, 5'b01010};
    vecs[3] = '{5'd9, 5'd10, 5'd8, 5'd6, 1'b0, 5'd10, 5'd0, 2'd1, 5'd17, 5'd26, 5'b10001};

    repeat (3) tick();
    chk("rst_phand", int'(phand), 0);
    chk("rst_dhand", int'(dhand), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_card_req", int'(card_req), 0);
    chk("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    tick();

    // reset asserted mid-DEAL while a request is outstanding
    start_game();
    serve(5'd7, 1);
    wait_busy();
    chk("middeal_busy", int'(busy), 1);
    chk("middeal_phand", int'(phand), 7);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_phand", int'(phand), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_card_req", int'(card_req), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    base = req_cnt;
    repeat (10) tick();
    chk("arst_no_req", req_cnt - base, 0);
    chk("arst_idle_busy", int'(busy), 0);

    for (int k = 0; k < 4; k++) begin
      vec_t v;
      v = vecs[k];
      start_game();
      base = req_cnt;
      serve(v.c0, 1);
      serve(v.c1, 2);
      serve(v.c2, 1);
      serve(v.c3, 3);
      repeat (3) tick();
      if (v.act) hit = 1'b1;
      else stand = 1'b1;
      tick();
      hit = 1'b0;
      stand = 1'b0;
      tick();
      if (v.n >= 2'd1) serve(v.e0, 2);
      if (v.n >= 2'd2) serve(v.e1, 1);
      wait_winner();
      repeat (5) tick();
      chk($sformatf("v%0d_phand", k), int'(phand), int'(v.p));
      chk($sformatf("v%0d_dhand", k), int'(dhand), int'(v.d));
      chk($sformatf("v%0d_winner", k), int'(winner), int'(v.w));
      chk($sformatf("v%0d_reqs", k), req_cnt - base, 4 + int'(v.n));
    end

    // invalid card values dropped, late valid accepted, hit+stand -> stand
    start_game();
    base = req_cnt;
    wait_busy();
    tick();
    card_valid = 1'b1;
    card_value = 5'd0;
    tick();
    chk("drop0_busy", int'(busy), 1);
    card_value = 5'd11;
    tick();
    chk("drop11_busy", int'(busy), 1);
    chk("drop_phand", int'(phand), 0);
    card_valid = 1'b0;
    card_value = 5'd0;
    repeat (3) tick();
    card_valid = 1'b1;
    card_value = 5'd4;
    tick();
    card_valid = 1'b0;
    card_value = 5'd0;
    chk("late4_phand", int'(phand), 4);
    chk("late4_busy", int'(busy), 0);
    chk("no_rereq", req_cnt - base, 1);
    serve(5'd10, 1);
    serve(5'd3, 2);
    serve(5'd10, 1);
    repeat (3) tick();
    hit = 1'b1;
    stand = 1'b1;
    tick();
    hit = 1'b0;
    stand = 1'b0;
    wait_winner();
    repeat (5) tick();
    chk("hs_winner", int'(winner), 5'b00010);
    chk("hs_phand", int'(phand), 7);
    chk("hs_reqs", req_cnt - base, 4);

    // new_game coincident with card_valid drops the card and restarts the deal
    start_game();
    wait_busy();
    tick();
    card_valid = 1'b1;
    card_value = 5'd5;
    new_game = 1'b1;
    tick();
    card_valid = 1'b0;
    card_value = 5'd0;
    chk("ngcv_phand", int'(phand), 0);
    chk("ngcv_busy", int'(busy), 0);
    serve(5'd2, 1);
    serve(5'd3, 1);
    new_game = 1'b0;
    serve(5'd4, 1);
    serve(5'd5, 1);
    tick();
    chk("ngcv_redeal_phand", int'(phand), 6);
    chk("ngcv_redeal_dhand", int'(dhand), 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
